// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the RNBIP-2 pipeline.
// Reads two-byte instructions (opcode, then operand) from byte-wide synchronous
// program memory and assembles them into 16-bit segments. Each segment is held
// with its next-PC in a small queue, and the queue head is presented downstream.
// A PC load from the control path flushes all wrong-path state.
module instr_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pm_addr,
  output logic        pm_rd,
  input  logic [7:0]  pm_data,
  input  logic        L_PC,
  input  logic [7:0]  pc_target,
  input  logic        stall,
  output logic        seg_valid,
  output logic [15:0] segment,
  output logic [7:0]  PC_in
);

  typedef enum logic {OPC, OPR} fetch_state_t;

  fetch_state_t state;
  logic [7:0]   pc;
  logic [7:0]   addr_hold;
  logic [1:0]   occ;
  logic [1:0]   infl;
  logic         head;

  logic [15:0]  q_seg [DEPTH];
  logic [7:0]   q_npc [DEPTH];

  logic         rd_vld_p1;
  logic         rd_opr_p1;
  logic [7:0]   rd_addr_p1;
  logic [7:0]   opcode_p1;

  logic         credit_ok;
  logic         rd_issue;
  logic         opc_issue;
  logic         push;
  logic         pop;
  logic         wr_idx;

  // The opcode read is gated only by registered state: start-of-cycle occupancy
  // plus instructions in flight. Stall and L_PC never reach pm_rd or pm_addr
  // combinationally, so a read issued in the redirect cycle is squashed instead.
  assign credit_ok = ({1'b0, occ} + {1'b0, infl}) < 3'd2;
  assign rd_issue  = !rst && ((state == OPR) || credit_ok);
  assign opc_issue = rd_issue && (state == OPC);
  assign pm_rd     = rd_issue;
  assign pm_addr   = rd_issue ? pc : addr_hold;

  // Operand data completes an instruction. Anything returning while a redirect
  // is in progress belongs to the wrong path and is dropped.
  assign push   = rd_vld_p1 && rd_opr_p1 && !L_PC;
  assign pop    = (occ != 2'd0) && !stall && !L_PC;
  // A push never meets a full queue, so the free slot is head + occ[0].
  assign wr_idx = head ^ occ[0];

  assign seg_valid = (occ != 2'd0);
  assign segment   = seg_valid ? q_seg[head] : 16'h0000;
  assign PC_in     = seg_valid ? q_npc[head] : 8'h00;

  // Control state: fetch FSM, PC, queue bookkeeping and read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OPC;
      pc        <= 8'h00;
      addr_hold <= 8'h00;
      occ       <= 2'd0;
      infl      <= 2'd0;
      head      <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else if (L_PC) begin
      state     <= OPC;
      pc        <= pc_target;
      addr_hold <= pm_addr;
      occ       <= 2'd0;
      infl      <= 2'd0;
      head      <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      if (rd_issue) begin
        pc        <= pc + 8'd1;
        state     <= (state == OPC) ? OPR : OPC;
        addr_hold <= pc;
      end
      occ       <= occ + {1'b0, push} - {1'b0, pop};
      infl      <= infl + {1'b0, opc_issue} - {1'b0, push};
      if (pop) begin
        head <= ~head;
      end
      rd_vld_p1 <= rd_issue;
    end
  end

  // ---- stage p0 -> p1: remember what was read; data returns next cycle ----
  // Datapath registers: opcode holding, read attributes and queue storage
  always_ff @(posedge clk) begin
    rd_opr_p1  <= (state == OPR);
    rd_addr_p1 <= pc;
    // ---- stage p1: capture returning byte, assemble and enqueue ----
    if (rd_vld_p1 && !rd_opr_p1) begin
      opcode_p1 <= pm_data;
    end
    if (push) begin
      q_seg[wr_idx] <= {opcode_p1, pm_data};
      q_npc[wr_idx] <= rd_addr_p1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pm_addr;
  logic        pm_rd;
  logic [7:0]  pm_data = 8'h00;
  logic        L_PC = 1'b0;
  logic [7:0]  pc_target = 8'h00;
  logic        stall = 1'b0;
  logic        seg_valid;
  logic [15:0] segment;
  logic [7:0]  PC_in;

  instr_fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data),
    .L_PC(L_PC), .pc_target(pc_target), .stall(stall),
    .seg_valid(seg_valid), .segment(segment), .PC_in(PC_in)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data for a read appears the following cycle
  logic [7:0] mem [256];
  always @(posedge clk) if (pm_rd) pm_data <= mem[pm_addr];

  int checks = 0;
  int failures = 0;

  // Reference model state: instruction queue, pending read, fetch pointer
  logic [15:0] mq_seg [$];
  logic [7:0]  mq_npc [$];
  logic [7:0]  m_pc, m_held, m_hold, last_addr;
  bit          m_opr, last_v, last_opr;
  int          m_infl;

  // Values sampled in the most recent step
  logic        s_rd, s_valid;
  logic [7:0]  s_addr, s_pcin;
  logic [15:0] s_seg;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_seg.delete();
    mq_npc.delete();
    m_pc = 8'h00; m_held = 8'h00; m_hold = 8'h00; last_addr = 8'h00;
    m_opr = 0; last_v = 0; last_opr = 0; m_infl = 0;
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance the model
  task automatic step(input logic st, input logic lp, input logic [7:0] tg);
    bit          exp_rd, exp_v;
    logic [7:0]  exp_addr, exp_npc;
    logic [15:0] exp_seg;
    stall = st; L_PC = lp; pc_target = tg;
    @(negedge clk);
    exp_rd   = m_opr || ((mq_seg.size() + m_infl) < 2);
    exp_addr = exp_rd ? m_pc : m_held;
    exp_v    = (mq_seg.size() != 0);
    exp_seg  = exp_v ? mq_seg[0] : 16'h0000;
    exp_npc  = exp_v ? mq_npc[0] : 8'h00;
    chk("pm_rd", {15'd0, pm_rd}, {15'd0, exp_rd});
    chk("pm_addr", {8'd0, pm_addr}, {8'd0, exp_addr});
    chk("seg_valid", {15'd0, seg_valid}, {15'd0, exp_v});
    chk("segment", segment, exp_seg);
    chk("PC_in", {8'd0, PC_in}, {8'd0, exp_npc});
    s_rd = pm_rd; s_addr = pm_addr; s_valid = seg_valid; s_seg = segment; s_pcin = PC_in;

    if (lp) begin
      mq_seg.delete(); mq_npc.delete();
      m_infl = 0; last_v = 0;
    end else begin
      if (last_v && !last_opr) m_hold = mem[last_addr];
      if (mq_seg.size() != 0 && !st) begin
        void'(mq_seg.pop_front());
        void'(mq_npc.pop_front());
      end
      if (last_v && last_opr) begin
        mq_seg.push_back({m_hold, mem[last_addr]});
        mq_npc.push_back(last_addr + 8'd1);
        m_infl--;
      end
      last_v = exp_rd;
      if (exp_rd) begin
        if (!m_opr) m_infl++;
        last_addr = m_pc;
        last_opr  = m_opr;
      end
    end
    if (exp_rd) m_held = m_pc;
    if (lp) begin
      m_pc = tg; m_opr = 0;
    end else if (exp_rd) begin
      m_pc = m_pc + 8'd1; m_opr = !m_opr;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; L_PC = 1'b0;
    @(posedge clk); #1;
    chk("rst_seg_valid", {15'd0, seg_valid}, 16'd0);
    chk("rst_segment", segment, 16'h0000);
    chk("rst_PC_in", {8'd0, PC_in}, 16'd0);
    chk("rst_pm_rd", {15'd0, pm_rd}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_basic();
    step(0, 0, 8'h00); chk("b0_rd", {15'd0, s_rd}, 16'd1); chk("b0_addr", {8'd0, s_addr}, 16'h00);
    step(0, 0, 8'h00); chk("b1_addr", {8'd0, s_addr}, 16'h01);
    step(0, 0, 8'h00); chk("b2_addr", {8'd0, s_addr}, 16'h02);
                       chk("b2_valid", {15'd0, s_valid}, 16'd0);
    step(0, 0, 8'h00); chk("b3_seg", s_seg, 16'h01AA); chk("b3_pcin", {8'd0, s_pcin}, 16'h02);
                       chk("b3_addr", {8'd0, s_addr}, 16'h03);
    step(0, 0, 8'h00); chk("b4_valid", {15'd0, s_valid}, 16'd0);
    step(0, 0, 8'h00); chk("b5_seg", s_seg, 16'h5217); chk("b5_pcin", {8'd0, s_pcin}, 16'h04);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h01; mem[1] = 8'hAA; mem[2] = 8'h52;
    mem[3] = 8'h17; mem[4] = 8'h00; mem[5] = 8'h00;
    mem[8'hFF] = 8'h0B;
    model_reset();

    // Basic fetch after reset
    do_reset();
    run_basic();

    // Stall from cycle 0: queue fills, fetch halts, then drains
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'h00);
      if (i == 5) begin
        chk("st5_seg", s_seg, 16'h01AA);
        chk("st5_rd", {15'd0, s_rd}, 16'd0);
      end
    end
    step(0, 0, 8'h00); chk("st8_seg", s_seg, 16'h01AA);
    step(0, 0, 8'h00); chk("st9_seg", s_seg, 16'h5217); chk("st9_pcin", {8'd0, s_pcin}, 16'h04);
                       chk("st9_addr", {8'd0, s_addr}, 16'h04); chk("st9_rd", {15'd0, s_rd}, 16'd1);
    step(0, 0, 8'h00); chk("st10_valid", {15'd0, s_valid}, 16'd0);

    // Redirect with a segment queued and reads in flight
    do_reset();
    repeat (3) step(0, 0, 8'h00);
    step(0, 1, 8'h40);
    step(0, 0, 8'h00); chk("rd1_valid", {15'd0, s_valid}, 16'd0); chk("rd1_addr", {8'd0, s_addr}, 16'h40);
    step(0, 0, 8'h00); chk("rd2_valid", {15'd0, s_valid}, 16'd0); chk("rd2_addr", {8'd0, s_addr}, 16'h41);
    step(0, 0, 8'h00); chk("rd3_valid", {15'd0, s_valid}, 16'd0);
    step(0, 0, 8'h00); chk("rd4_seg", s_seg, {mem[8'h40], mem[8'h41]}); chk("rd4_pcin", {8'd0, s_pcin}, 16'h42);

    // Redirect and stall together with a full queue
    do_reset();
    repeat (6) step(1, 0, 8'h00);
    chk("fs_full_rd", {15'd0, s_rd}, 16'd0);
    step(1, 1, 8'h80);
    step(0, 0, 8'h00); chk("fs1_valid", {15'd0, s_valid}, 16'd0); chk("fs1_addr", {8'd0, s_addr}, 16'h80);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00); chk("fs4_seg", s_seg, {mem[8'h80], mem[8'h81]}); chk("fs4_pcin", {8'd0, s_pcin}, 16'h82);

    // Reset pulsed with an instruction half assembled
    do_reset();
    repeat (2) step(0, 0, 8'h00);
    do_reset();
    run_basic();

    // Redirect to the top of memory: operand wraps to 0x00
    mem[8'h00] = 8'h33;
    do_reset();
    repeat (2) step(0, 0, 8'h00);
    step(0, 1, 8'hFF);
    step(0, 0, 8'h00); chk("wr1_addr", {8'd0, s_addr}, 16'hFF);
    step(0, 0, 8'h00); chk("wr2_addr", {8'd0, s_addr}, 16'h00);
    step(0, 0, 8'h00); chk("wr3_addr", {8'd0, s_addr}, 16'h01); chk("wr3_rd", {15'd0, s_rd}, 16'd1);
    step(0, 0, 8'h00); chk("wr4_seg", s_seg, 16'h0B33); chk("wr4_pcin", {8'd0, s_pcin}, 16'h01);

    // Random stall and redirect traffic
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, ($urandom % 25) == 0, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
